// File: rtl/shift_sequencer_8bit_pkg.sv
// Shared types for the multi-step shift sequencer: FSM states and the captured shift mode.
package shift_sequencer_8bit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Bit order matches the op decoder's mode field: {rot, la, lr}.
  typedef struct packed {
    logic rot;
    logic la;
    logic lr;
  } shift_mode_t;

endpackage

// File: rtl/shift_sequencer_8bit_shifter.sv
// Combinational single-step 8-bit shifter: logical/arithmetic shift or rotate by one position.
module shifter_8bit (
  input  logic [7:0] i,
  input  logic       lr,
  input  logic       la,
  input  logic       rot,
  output logic [7:0] o
);

  always_comb begin
    o = '0;
    if (!lr) begin
      o = {i[6:0], (rot ? i[7] : 1'b0)};
    end else if (rot) begin
      o = {i[0], i[7:1]};
    end else begin
      o = {(la ? i[7] : 1'b0), i[7:1]};
    end
  end

endmodule

// File: rtl/shift_sequencer_8bit.sv
// Iterates the single-step shifter N times per request over valid/ready handshakes.
module shift_sequencer_8bit
  import shift_sequencer_8bit_pkg::*;
#(
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       operand,
  input  logic [AMT_W-1:0] amount,
  input  logic             lr,
  input  logic             la,
  input  logic             rot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       result,
  output logic             last_out
);

  state_e           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  shift_mode_t      mode_q, mode_d;
  logic             last_q, last_d;
  logic [7:0]       shf_o;

  shifter_8bit u_shf (
    .i   (op_q),
    .lr  (mode_q.lr),
    .la  (mode_q.la),
    .rot (mode_q.rot),
    .o   (shf_o)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = operand;
          cnt_d   = amount;
          mode_d  = '{rot: rot, la: la, lr: lr};
          last_d  = 1'b0;
          state_d = (amount == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        op_d   = shf_o;
        cnt_d  = cnt_q - AMT_W'(1);
        last_d = mode_q.lr ? op_q[0] : op_q[7];
        if (cnt_q == AMT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush wins over everything, including an accept in the same cycle.
    if (clear) begin
      state_d = S_IDLE;
      op_d    = '0;
      cnt_d   = '0;
      mode_d  = '0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = op_q;
  assign last_out  = last_q;

endmodule
